motor_ramp_pwm: RTL
===================

Name: motor_ramp_pwm

Overview:
- N-channel signed-duty DC motor driver between the car's steering/mode logic and the H-bridge pins. Generalises the fixed two-motor PWM block.
- Per-channel signed target duty, slew-rate-limited ramp once per PWM period, enforced zero-duty dead time before any direction reversal, immediate brake, and per-channel at-target status.

Parameters:
- N_CH, 2, number of motor channels
- DUTY_W, 10, duty magnitude width; signed duty width is DUTY_W+1
- PERIOD, 4000, PWM period in clk cycles (≥2)
- CNT_W, 12, period counter width (2^CNT_W ≥ PERIOD)
- STEP_UP, 23, max |duty| increase per period
- STEP_DN, 100, max |duty| decrease per period
- DEAD_PERIODS, 2, whole periods held at duty 0 before a sign flip (0 = none)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- target  in  N_CH*(DUTY_W+1)  signed target duty per channel; ch i at [i*(DUTY_W+1) +: DUTY_W+1]
- brake  in  N_CH  per-channel brake; forces duty 0
- pwm  out  N_CH  PWM drive per channel
- dir  out  N_CH  1 = backward, 0 = forward
- duty  out  N_CH*(DUTY_W+1)  current signed duty per channel, same packing as target
- at_target  out  N_CH  1 when current duty equals the clamped target
- period_tick  out  1  one-cycle pulse on the last cycle of each period

Behaviour:
- Reset (rst=0, async): count=0, all duty=0, dir=0, pwm=0, threshold=0, dead counters=0, period_tick=0. at_target is then combinational from duty and target.
- Counter: count runs 0..PERIOD-1 and wraps to 0. period_tick=1 when count==PERIOD-1.
- Target clamp: target of -2^DUTY_W is treated as -(2^DUTY_W-1). All comparisons use clamped target T.
- Duty update: only on a period_tick cycle, effective next clock. Per channel, current duty D:
  - brake[i]=1: D←0 immediately at the next clock, regardless of tick. Dead counter loads DEAD_PERIODS. Threshold←0 at the same clock.
  - T, D same sign or D==0 with no dead-time pending: move |D| toward |T| by at most STEP_UP when growing and STEP_DN when shrinking, no overshoot.
  - Sign(T) ≠ sign(D), D≠0: shrink |D| toward 0 by at most STEP_DN. On reaching 0, load the dead counter with DEAD_PERIODS.
  - Dead counter >0: D holds 0; decrement once per tick. Direction may change only on the tick after the counter reads 0.
  - A target change mid-ramp takes effect on the next tick. No restart of the dead counter unless the sign flips again.
- dir: registered. Equals the sign bit of D when D≠0. Holds its last value while D==0.
- Threshold: thr = (PERIOD*|D|) >> DUTY_W, computed with full-width product (CNT_W+DUTY_W bits). Latched only at period boundaries (and brake), so pwm is glitch-free within a period.
- pwm: registered, pwm ← (count < thr); one-cycle latency from count. |D|=0 gives constant 0. |D|=1023 (PERIOD=4000) gives 3996 high cycles/period.
- Arithmetic: |D| bounded to [0, 2^DUTY_W-1]. Saturate, never wrap.
- Simultaneous events: brake dominates ramp and dead-time logic. Target change on a tick cycle uses the new target. Releasing brake resumes ramping from 0 after the dead counter expires.
- Reset mid-operation: outputs return to reset values within the asserting edge. Ramping restarts from 0 after release.

Test Plan:
- Reset hold, then release with target=0 for both channels -> pwm=0, dir=0, duty=0, at_target=1; period_tick every 4000 cycles, first at cycle 3999.
- ch0 target=+1023 from 0 -> duty increments by 23 per tick: 23, 46, … 1012, then 1023 on the 45th tick; at_target rises then; pwm high 3996 of 4000 cycles.
- ch0 duty=+500, target changed to -400 -> duty 400, 300, 200, 100, 0 on 5 ticks; dir stays 0 for 2 further ticks at 0; next tick duty=-23 with dir=1; reaches -400 after 18 growth ticks.
- ch1 at +1023, brake[1] pulsed mid-period -> next clock duty=0, pwm=0 from following cycle. Release: 2 dead ticks at 0, then ramp +23/tick.
- Duty +512 steady -> thr=2000; pwm high exactly cycles 1..2000 of each period (one-cycle lag), low for 2000.
- rst asserted mid-ramp at duty -300 -> immediately duty=0, dir=0, pwm=0, count=0. After release, ramp from 0 toward target.

Source files
------------

// File: rtl/motor_ramp_pwm.sv
// N-channel signed-duty DC motor driver: slew-limited ramp per PWM period,
// zero-duty dead time before direction reversal, immediate brake.
module motor_ramp_pwm #(
    parameter int N_CH         = 2,
    parameter int DUTY_W       = 10,
    parameter int PERIOD       = 4000,
    parameter int CNT_W        = 12,
    parameter int STEP_UP      = 23,
    parameter int STEP_DN      = 100,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH*(DUTY_W+1)-1:0]   target,
    input  logic [N_CH-1:0]              brake,
    output logic [N_CH-1:0]              pwm,
    output logic [N_CH-1:0]              dir,
    output logic [N_CH*(DUTY_W+1)-1:0]   duty,
    output logic [N_CH-1:0]              at_target,
    output logic                         period_tick
);

    localparam int SD_W    = DUTY_W + 1;
    localparam int MAG_MAX = (2 ** DUTY_W) - 1;
    localparam int UP_SAT  = (STEP_UP > MAG_MAX) ? MAG_MAX : STEP_UP;
    localparam int DN_SAT  = (STEP_DN > MAG_MAX) ? MAG_MAX : STEP_DN;
    localparam int DEAD_W  = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);

    localparam logic [DUTY_W:0]   STEP_UP_W = (DUTY_W + 1)'(UP_SAT);
    localparam logic [DUTY_W-1:0] STEP_DN_W = DUTY_W'(DN_SAT);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PERIODS);
    localparam logic [CNT_W-1:0]  PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [SD_W-1:0]   NEG_FULL  = {1'b1, {DUTY_W{1'b0}}};
    localparam logic [SD_W-1:0]   NEG_SAT   = {1'b1, {(DUTY_W-1){1'b0}}, 1'b1};

    // Move a magnitude toward goal by at most one step, never overshooting.
    function automatic logic [DUTY_W-1:0] approach(input logic [DUTY_W-1:0] cur,
                                                   input logic [DUTY_W-1:0] goal);
        logic [DUTY_W:0]   grown;
        logic [DUTY_W-1:0] gap;
        grown = {1'b0, cur} + STEP_UP_W;
        gap   = cur - goal;
        if (goal > cur)
            approach = (grown >= {1'b0, goal}) ? goal : grown[DUTY_W-1:0];
        else if (gap > STEP_DN_W)
            approach = cur - STEP_DN_W;
        else
            approach = goal;
    endfunction

    function automatic logic [CNT_W-1:0] thr_of(input logic [DUTY_W-1:0] mag);
        logic [CNT_W+DUTY_W-1:0] prod;
        prod   = {{DUTY_W{1'b0}}, PERIOD_C} * {{CNT_W{1'b0}}, mag};
        thr_of = prod[CNT_W+DUTY_W-1:DUTY_W];
    endfunction

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick;

    assign tick        = (count_q == CNT_LAST);
    assign period_tick = tick;

    always_comb begin
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SD_W-1:0]   t_raw, t_clamp;
        logic [SD_W-1:0]   duty_q, duty_d;
        logic [DUTY_W-1:0] t_mag, d_mag, mag_n;
        logic              t_neg, t_zero, d_neg, d_zero, neg_n;
        logic              dir_q, dir_d, pwm_q, pwm_d;
        logic [CNT_W-1:0]  thr_q, thr_d;
        logic [DEAD_W-1:0] dead_q, dead_d;

        assign t_raw = target[i*SD_W +: SD_W];

        always_comb begin
            t_clamp = (t_raw == NEG_FULL) ? NEG_SAT : t_raw;
            t_neg   = t_clamp[SD_W-1];
            t_zero  = (t_clamp == '0);
            t_mag   = t_neg ? (~t_clamp[DUTY_W-1:0] + DUTY_W'(1)) : t_clamp[DUTY_W-1:0];
            d_neg   = duty_q[SD_W-1];
            d_zero  = (duty_q == '0);
            d_mag   = d_neg ? (~duty_q[DUTY_W-1:0] + DUTY_W'(1)) : duty_q[DUTY_W-1:0];
        end

        always_comb begin
            mag_n  = d_mag;
            neg_n  = d_neg;
            dead_d = dead_q;
            if (brake[i]) begin
                mag_n  = '0;
                dead_d = DEAD_LOAD;
            end else if (tick) begin
                if (dead_q != '0) begin
                    mag_n  = '0;
                    dead_d = dead_q - DEAD_W'(1);
                end else if (d_zero) begin
                    mag_n = approach('0, t_mag);
                    neg_n = t_neg;
                end else if (!t_zero && (t_neg != d_neg)) begin
                    // Reversal: wind down to zero, then hold there for the dead time.
                    mag_n = approach(d_mag, '0);
                    if (mag_n == '0) dead_d = DEAD_LOAD;
                end else begin
                    mag_n = approach(d_mag, t_mag);
                end
            end
            duty_d = neg_n ? -{1'b0, mag_n} : {1'b0, mag_n};
            dir_d  = (mag_n != '0) ? neg_n : dir_q;
            thr_d  = (brake[i] || tick) ? thr_of(mag_n) : thr_q;
            pwm_d  = (count_q < thr_q);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                duty_q <= '0;
                dir_q  <= 1'b0;
                pwm_q  <= 1'b0;
                thr_q  <= '0;
                dead_q <= '0;
            end else begin
                duty_q <= duty_d;
                dir_q  <= dir_d;
                pwm_q  <= pwm_d;
                thr_q  <= thr_d;
                dead_q <= dead_d;
            end
        end

        assign duty[i*SD_W +: SD_W] = duty_q;
        assign dir[i]               = dir_q;
        assign pwm[i]               = pwm_q;
        assign at_target[i]         = (duty_q == t_clamp);
    end

endmodule
